exception_unit: RTL

Sequences exception entry for the multicycle CPU and sits directly upstream of the PC-source mux.
- On an exception request it saves the faulting PC into EPC and reads the handler byte from the vector table in memory (addresses 253..255).
- It presents the zero-extended handler address as the mux's exception-address input (PCSource = 5), and EPC as the mux's EPC input (PCSource = 4).
- It then strobes a PC write so the next fetch starts at the handler.

---
 rtl/exception_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/exception_unit.sv
// Exception entry sequencer: saves EPC/cause, fetches the handler byte from the
// vector table and strobes a PC write to the zero-extended handler address.
module exception_unit #(
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExcRequest,
  input  logic [1:0]  ExcCode,
  input  logic [31:0] PCOut,
  input  logic [31:0] MemDataOut,
  output logic [31:0] MemAddrExc,
  output logic        MemAddrSel,
  output logic [31:0] RegEPCOut,
  output logic [31:0] ExceptionBit,
  output logic [1:0]  CauseOut,
  output logic        PCWriteExc,
  output logic        PCSourceExc,
  output logic        Busy,
  output logic        Dropped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    JUMP = 2'd3
  } state_t;

  localparam logic [2:0]  LAT_C = 3'(MEM_LAT);
  localparam logic [31:0] VEC_C = 32'(VEC_BASE);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;
  logic        dropped_q, dropped_d;
  logic [1:0]  code_s;
  logic        unused_data_s;

  // Reserved cause is folded onto invalid-opcode so it still has a vector entry.
  assign code_s        = (ExcCode == 2'd3) ? 2'd0 : ExcCode;
  assign unused_data_s = ^MemDataOut[31:8];

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      epc_q     <= 32'd0;
      exc_q     <= 32'd0;
      cause_q   <= 2'd0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state logic; READ leaves when the counter reaches 1, so it lasts MEM_LAT cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    exc_d     = exc_q;
    cause_d   = cause_q;
    dropped_d = dropped_q | (ExcRequest & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (ExcRequest) begin
          epc_d   = PCOut - 32'd4;
          cause_d = code_s;
          cnt_d   = LAT_C;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = LOAD;
        end else begin
          state_d = READ;
        end
      end
      LOAD: begin
        exc_d   = {24'd0, MemDataOut[7:0]};
        state_d = JUMP;
      end
      JUMP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combinational state decodes toward the memory and PC-source muxes.
  always_comb begin
    MemAddrSel  = 1'b0;
    MemAddrExc  = 32'd0;
    PCWriteExc  = 1'b0;
    PCSourceExc = 1'b0;
    case (state_q)
      READ, LOAD: begin
        MemAddrSel = 1'b1;
        MemAddrExc = VEC_C + {30'd0, cause_q};
      end
      JUMP: begin
        PCWriteExc  = 1'b1;
        PCSourceExc = 1'b1;
      end
      default: begin
        MemAddrSel = 1'b0;
      end
    endcase
  end

  assign Busy         = (state_q != IDLE);
  assign RegEPCOut    = epc_q;
  assign ExceptionBit = exc_q;
  assign CauseOut     = cause_q;
  assign Dropped      = dropped_q;

endmodule
